hex_msg_feeder: RTL and testbench



---
 rtl/hex_msg_pkg.sv | 26 ++
 rtl/hex_char_seg_decoder.sv | 32 +++
 rtl/hex_msg_feeder.sv | 141 ++++++++++++++
 tb/tb_hex_msg_feeder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/hex_msg_pkg.sv
// Shared character codes and segment constants for the scrolling message feeder.
package hex_msg_pkg;

    localparam int CODE_W_DEF = 4;
    localparam int N_SLOTS    = 6;

    localparam logic [3:0] CH_B     = 4'd0;
    localparam logic [3:0] CH_I     = 4'd1;
    localparam logic [3:0] CH_N     = 4'd2;
    localparam logic [3:0] CH_E     = 4'd3;
    localparam logic [3:0] CH_G     = 4'd4;
    localparam logic [3:0] CH_BLANK = 4'd5;
    localparam logic [3:0] CH_F     = 4'd6;
    localparam logic [3:0] CH_S     = 4'd7;
    localparam logic [3:0] CH_H     = 4'd8;
    localparam logic [3:0] CH_O     = 4'd9;
    localparam logic [3:0] CH_A     = 4'd10;
    localparam logic [3:0] CH_T     = 4'd11;
    localparam logic [3:0] CH_R     = 4'd12;
    localparam logic [3:0] CH_P     = 4'd13;
    localparam logic [3:0] CH_L     = 4'd14;

    // Active-low, bit order gfedcba.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/hex_char_seg_decoder.sv
// Combinational character-code to 7-segment (active-low, gfedcba) decoder.
module hex_char_seg_decoder
    import hex_msg_pkg::*;
#(
    parameter int CODE_W = CODE_W_DEF
) (
    input  logic [CODE_W-1:0] code_i,
    output logic [6:0]        seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (code_i)
            CODE_W'(CH_B): seg_o = 7'b0000011;
            CODE_W'(CH_I): seg_o = 7'b1111001;
            CODE_W'(CH_N): seg_o = 7'b0101011;
            CODE_W'(CH_E): seg_o = 7'b0000110;
            CODE_W'(CH_G): seg_o = 7'b1000010;
            CODE_W'(CH_F): seg_o = 7'b0001110;
            CODE_W'(CH_S): seg_o = 7'b0010010;
            CODE_W'(CH_H): seg_o = 7'b0001001;
            CODE_W'(CH_O): seg_o = 7'b1000000;
            CODE_W'(CH_A): seg_o = 7'b0001000;
            CODE_W'(CH_T): seg_o = 7'b0000111;
            CODE_W'(CH_R): seg_o = 7'b0101111;
            CODE_W'(CH_P): seg_o = 7'b0001100;
            CODE_W'(CH_L): seg_o = 7'b1000111;
            default:       seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_msg_feeder.sv
// Buffers pushed character codes and scrolls them right-to-left across HEX5..HEX0.
// Define HEX_MSG_LOOP_EN to recirculate popped characters so the message repeats.
module hex_msg_feeder
    import hex_msg_pkg::*;
#(
    parameter int TICK_DIV   = 50000000,
    parameter int FIFO_DEPTH = 8,
    parameter int CODE_W     = CODE_W_DEF
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              char_valid,
    input  logic [CODE_W-1:0] char_code,
    output logic              char_ready,
    input  logic              clear,
    output logic              busy,
    output logic [6:0]        HEX5,
    output logic [6:0]        HEX4,
    output logic [6:0]        HEX3,
    output logic [6:0]        HEX2,
    output logic [6:0]        HEX1,
    output logic [6:0]        HEX0
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CODE_W-1:0] BLANK_CODE = CODE_W'(CH_BLANK);

    logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CODE_W-1:0] mem_q  [FIFO_DEPTH];
    logic [CODE_W-1:0] mem_d  [FIFO_DEPTH];
    logic [CODE_W-1:0] slot_q [N_SLOTS];
    logic [CODE_W-1:0] slot_d [N_SLOTS];

    logic              tick;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [CODE_W-1:0] head;
    logic [PW-1:0]     wr_nxt;
    logic [CW-1:0]     cnt_nxt;
    logic              slots_blank;
    logic [6:0]        seg_w [N_SLOTS];

    assign tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    assign full       = (count_q == CW'(FIFO_DEPTH));
    assign empty      = (count_q == '0);
    assign char_ready = !full && !clear;
    assign push       = char_valid && char_ready;
    assign pop        = tick && !empty;
    assign head       = mem_q[rd_ptr_q];

    always_comb begin
        slots_blank = 1'b1;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (slot_q[i] != BLANK_CODE) slots_blank = 1'b0;
        end
    end

    assign busy = !empty || !slots_blank;

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        rd_ptr_d   = rd_ptr_q;
        mem_d      = mem_q;
        slot_d     = slot_q;
        wr_nxt     = wr_ptr_q;
        cnt_nxt    = count_q;

        if (tick) begin
            for (int i = N_SLOTS - 1; i > 0; i--) slot_d[i] = slot_q[i-1];
            slot_d[0] = pop ? head : BLANK_CODE;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
`ifdef HEX_MSG_LOOP_EN
            // Recirculated character lands ahead of any external push this cycle.
            mem_d[wr_nxt] = head;
            wr_nxt        = wr_nxt + PW'(1);
`else
            cnt_nxt = cnt_nxt - CW'(1);
`endif
        end

        if (push) begin
            mem_d[wr_nxt] = char_code;
            wr_nxt        = wr_nxt + PW'(1);
            cnt_nxt       = cnt_nxt + CW'(1);
        end

        wr_ptr_d = wr_nxt;
        count_d  = cnt_nxt;

        if (clear) begin
            tick_cnt_d = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            for (int i = 0; i < N_SLOTS; i++) slot_d[i] = BLANK_CODE;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= BLANK_CODE;
            for (int i = 0; i < N_SLOTS; i++)    slot_q[i] <= BLANK_CODE;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            mem_q      <= mem_d;
            slot_q     <= slot_d;
        end
    end

    for (genvar g = 0; g < N_SLOTS; g++) begin : g_dec
        hex_char_seg_decoder #(.CODE_W(CODE_W)) u_dec (
            .code_i (slot_q[g]),
            .seg_o  (seg_w[g])
        );
    end

    assign HEX0 = seg_w[0];
    assign HEX1 = seg_w[1];
    assign HEX2 = seg_w[2];
    assign HEX3 = seg_w[3];
    assign HEX4 = seg_w[4];
    assign HEX5 = seg_w[5];

endmodule

// File: tb/tb_hex_msg_feeder.sv
// Directed self-checking bench for hex_msg_feeder with TICK_DIV=4, FIFO_DEPTH=8.
module tb_hex_msg_feeder;
    import hex_msg_pkg::*;

    localparam int TICK_DIV   = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int CODE_W     = 4;
    localparam logic [41:0] BLANK6 = {6{7'b1111111}};

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       char_valid;
    logic [3:0] char_code;
    logic       char_ready;
    logic       clear;
    logic       busy;
    logic [6:0] HEX5, HEX4, HEX3, HEX2, HEX1, HEX0;

    int tests = 0;
    int fails = 0;

    hex_msg_feeder #(
        .TICK_DIV   (TICK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CODE_W     (CODE_W)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .char_valid (char_valid),
        .char_code  (char_code),
        .char_ready (char_ready),
        .clear      (clear),
        .busy       (busy),
        .HEX5       (HEX5),
        .HEX4       (HEX4),
        .HEX3       (HEX3),
        .HEX2       (HEX2),
        .HEX1       (HEX1),
        .HEX0       (HEX0)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [6:0] seg(input logic [3:0] c);
        case (c)
            4'd0:    return 7'b0000011;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0101011;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1000010;
            4'd6:    return 7'b0001110;
            4'd7:    return 7'b0010010;
            4'd8:    return 7'b0001001;
            4'd9:    return 7'b1000000;
            4'd10:   return 7'b0001000;
            4'd11:   return 7'b0000111;
            4'd12:   return 7'b0101111;
            4'd13:   return 7'b0001100;
            4'd14:   return 7'b1000111;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic push_one(input logic [3:0] c);
        char_valid = 1'b1;
        char_code  = c;
        step();
        char_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    function automatic logic [41:0] hex_all();
        return {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
    endfunction

    logic [3:0] msg [6];
    logic [3:0] fc  [10];
    logic [3:0] loop_seq [5];

    initial begin
        msg      = '{CH_F, CH_I, CH_N, CH_I, CH_S, CH_H};
        fc       = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
        // Ticks 2.. show the loaded ring order: B recirculates behind G before I,N arrive.
        loop_seq = '{CH_E, CH_G, CH_B, CH_I, CH_N};

        reset      = 1'b1;
        char_valid = 1'b0;
        char_code  = '0;
        clear      = 1'b0;
        #12;
        chk("reset_hex", 64'(hex_all()), 64'(BLANK6));
        chk("reset_ready", 64'(char_ready), 64'd1);
        chk("reset_busy", 64'(busy), 64'd0);
        reset = 1'b0;

        // Reset mid-count with a queued character.
        push_one(CH_A);
        step();
        chk("pre_reset_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("midreset_hex", 64'(hex_all()), 64'(BLANK6));
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_ready", 64'(char_ready), 64'd1);
        #1;
        reset = 1'b0;
        push_one(CH_H);
        step();
        step();
        chk("restart_no_tick_yet", 64'(HEX0), 64'(SEG_BLANK));
        step();
        chk("restart_tick4", 64'(HEX0), 64'(seg(CH_H)));
        do_clear();

        // Basic scroll of FINISH.
        for (int i = 0; i < 6; i++) push_one(msg[i]);
        repeat (18) step();
        chk("scroll_hex", 64'(hex_all()),
            64'({seg(CH_F), seg(CH_I), seg(CH_N), seg(CH_I), seg(CH_S), seg(CH_H)}));
        chk("scroll_busy", 64'(busy), 64'd1);
        repeat (24) step();
        chk("scroll_off_hex", 64'(hex_all()), 64'(BLANK6));
        chk("scroll_off_busy", 64'(busy), 64'd0);

        // Fill the FIFO; ticks at edges 4 and 8 each drain one entry.
        do_clear();
        for (int i = 0; i < 10; i++) begin
            char_valid = 1'b1;
            char_code  = fc[i];
            step();
            if (i == 8) chk("ready_before_full", 64'(char_ready), 64'd1);
        end
        chk("full_ready_low", 64'(char_ready), 64'd0);
        char_code = CH_T;
        step();
        chk("full_ninth_ignored_ready", 64'(char_ready), 64'd0);
        step();
        chk("full_ready_after_tick", 64'(char_ready), 64'd1);
        char_valid = 1'b0;
        repeat (28) step();
        chk("full_order_hex", 64'(hex_all()),
            64'({seg(fc[4]), seg(fc[5]), seg(fc[6]), seg(fc[7]), seg(fc[8]), seg(fc[9])}));
        repeat (4) step();
        chk("full_no_ninth_hex0", 64'(HEX0), 64'(SEG_BLANK));
        chk("full_last_hex1", 64'(HEX1), 64'(seg(fc[9])));

        // Push coinciding with a tick.
        do_clear();
        push_one(CH_P);
        push_one(CH_L);
        push_one(CH_O);
        push_one(CH_E);
        chk("tick_push_head", 64'(HEX0), 64'(seg(CH_P)));
        repeat (12) step();
        chk("tick_push_order", 64'({HEX3, HEX2, HEX1, HEX0}),
            64'({seg(CH_P), seg(CH_L), seg(CH_O), seg(CH_E)}));
        repeat (4) step();
        chk("tick_push_drained", 64'({HEX4, HEX0}), 64'({seg(CH_P), SEG_BLANK}));

        // Clear during scroll with a competing push.
        do_clear();
        push_one(CH_G);
        push_one(CH_O);
        repeat (3) step();
        chk("clear_pre_hex0", 64'(HEX0), 64'(seg(CH_G)));
        clear      = 1'b1;
        char_valid = 1'b1;
        char_code  = CH_A;
        #1;
        chk("clear_ready_low", 64'(char_ready), 64'd0);
        step();
        clear      = 1'b0;
        char_valid = 1'b0;
        chk("clear_hex", 64'(hex_all()), 64'(BLANK6));
        chk("clear_busy", 64'(busy), 64'd0);
        push_one(CH_H);
        step();
        step();
        chk("clear_no_early_tick", 64'(HEX0), 64'(SEG_BLANK));
        step();
        chk("clear_tick_after4", 64'(HEX0), 64'(seg(CH_H)));

`ifdef HEX_MSG_LOOP_EN
        do_clear();
        push_one(CH_B);
        push_one(CH_E);
        push_one(CH_G);
        step();
        chk("loop_tick1", 64'(HEX0), 64'(seg(CH_B)));
        push_one(CH_I);
        push_one(CH_N);
        step();
        step();
        for (int k = 2; k <= 50; k++) begin
            if (k > 2) repeat (4) step();
            chk("loop_hex0", 64'(HEX0), 64'(seg(loop_seq[(k - 2) % 5])));
        end
        chk("loop_busy", 64'(busy), 64'd1);
        do_clear();
        chk("loop_clear_hex", 64'(hex_all()), 64'(BLANK6));
        chk("loop_clear_busy", 64'(busy), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
